// File: rtl/timer_counter.sv
// timer_counter: 8051-style timer/counter with 13-bit, 16-bit, 8-bit
// auto-reload and hold modes. It counts either machine-cycle strobes (CE)
// or falling edges on the asynchronous pin T, sampled once per machine cycle.
// Optional build macro COUNTER_GATE_EN adds the GATE/INT run qualifier.
module timer_counter (
  input  logic       CLK,
  input  logic       RSTdash,
  input  logic       T,
  input  logic       CE,
  input  logic       TR,
  input  logic       CT,
  input  logic [1:0] M,
  input  logic       WRL,
  input  logic       WRH,
  input  logic [7:0] DIN,
  input  logic       TFCLR,
`ifdef COUNTER_GATE_EN
  input  logic       GATE,
  input  logic       INT,
`endif
  output logic [7:0] TL,
  output logic [7:0] TH,
  output logic       TF
);

  localparam logic [1:0] MODE_13   = 2'd0;
  localparam logic [1:0] MODE_16   = 2'd1;
  localparam logic [1:0] MODE_8RLD = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  logic       sync1;
  logic       sync2;
  logic       samp;
  logic       fall;
  logic       run;
  logic       tick;
  logic       write;
  logic       ovf;
  logic [7:0] tl_nxt;
  logic [7:0] th_nxt;

  // Two-flop synchroniser for T plus the per-machine-cycle sample; the sample
  // keeps tracking even while stopped so no stale edge survives a restart.
  always_ff @(posedge CLK or negedge RSTdash) begin
    if (!RSTdash) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      samp  <= 1'b1;
    end else begin
      sync1 <= T;
      sync2 <= sync1;
      if (CE) samp <= sync2;
    end
  end

  assign fall = CE & samp & ~sync2;

`ifdef COUNTER_GATE_EN
  logic int_sync1;
  logic int_sync2;

  // Synchronise INT before it qualifies the run enable.
  always_ff @(posedge CLK or negedge RSTdash) begin
    if (!RSTdash) begin
      int_sync1 <= 1'b0;
      int_sync2 <= 1'b0;
    end else begin
      int_sync1 <= INT;
      int_sync2 <= int_sync1;
    end
  end

  assign run = TR & (~GATE | int_sync2);
`else
  assign run = TR;
`endif

  assign tick  = run & CE & (CT ? fall : 1'b1);
  assign write = WRL | WRH;

  // Next count value; a register write swallows a coincident tick entirely.
  always_comb begin
    tl_nxt = TL;
    th_nxt = TH;
    ovf    = 1'b0;
    if (write) begin
      if (WRL) tl_nxt = DIN;
      if (WRH) th_nxt = DIN;
    end else if (tick) begin
      case (M)
        MODE_13:   {ovf, th_nxt, tl_nxt[4:0]} = {1'b0, TH, TL[4:0]} + 14'd1;
        MODE_16:   {ovf, th_nxt, tl_nxt} = {1'b0, TH, TL} + 17'd1;
        MODE_8RLD: begin
          if (TL == 8'hFF) begin
            tl_nxt = TH;
            ovf    = 1'b1;
          end else begin
            tl_nxt = TL + 8'd1;
          end
        end
        MODE_HOLD: ;
        default:   ;
      endcase
    end
  end

  // Count registers and overflow flag; overflow beats a simultaneous clear.
  always_ff @(posedge CLK or negedge RSTdash) begin
    if (!RSTdash) begin
      TL <= 8'h00;
      TH <= 8'h00;
      TF <= 1'b0;
    end else begin
      TL <= tl_nxt;
      TH <= th_nxt;
      if (ovf)        TF <= 1'b1;
      else if (TFCLR) TF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter. Expected TH/TL/TF triples are
// queued as stimulus is applied and popped when the result is observable.
// Define COUNTER_GATE_EN to also exercise the GATE/INT qualifier.
module tb_timer_counter;

  logic       CLK;
  logic       RSTdash;
  logic       T;
  logic       CE;
  logic       TR;
  logic       CT;
  logic [1:0] M;
  logic       WRL;
  logic       WRH;
  logic [7:0] DIN;
  logic       TFCLR;
  logic [7:0] TL;
  logic [7:0] TH;
  logic       TF;
`ifdef COUNTER_GATE_EN
  logic       GATE;
  logic       INT;
`endif

  typedef struct {
    string      name;
    logic [7:0] th;
    logic [7:0] tl;
    logic       tf;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  timer_counter dut (
    .CLK(CLK), .RSTdash(RSTdash), .T(T), .CE(CE), .TR(TR), .CT(CT), .M(M),
    .WRL(WRL), .WRH(WRH), .DIN(DIN), .TFCLR(TFCLR),
`ifdef COUNTER_GATE_EN
    .GATE(GATE), .INT(INT),
`endif
    .TL(TL), .TH(TH), .TF(TF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One CE strobe followed by three idle cycles (CE period = 4 CLK).
  task automatic ce_pulse();
    CE = 1'b1;
    @(negedge CLK);
    CE = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic wr(input logic l, input logic h, input logic [7:0] d);
    WRL = l; WRH = h; DIN = d;
    @(negedge CLK);
    WRL = 1'b0; WRH = 1'b0;
  endtask

  task automatic clr_tf();
    TFCLR = 1'b1;
    @(negedge CLK);
    TFCLR = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    exp_q.push_back('{"reset", 8'h00, 8'h00, 1'b0});
    e = exp_q.pop_front();
    checks++;
    if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
      errors++;
      $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
               e.name, TH, TL, TF, e.th, e.tl, e.tf);
    end
    @(negedge CLK);
    RSTdash = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_mode1();
    M = 2'd1; CT = 1'b0; TR = 1'b0;
    wr(1'b1, 1'b0, 8'hFE);
    wr(1'b0, 1'b1, 8'hFF);
    TR = 1'b1;
    exp_q.push_back('{"m1_ffff", 8'hFF, 8'hFF, 1'b0});
    exp_q.push_back('{"m1_wrap", 8'h00, 8'h00, 1'b1});
    for (int i = 0; i < 2; i++) begin
      ce_pulse();
      e = exp_q.pop_front();
      checks++;
      if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
        errors++;
        $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
                 e.name, TH, TL, TF, e.th, e.tl, e.tf);
      end
    end
  endtask

  task automatic test_mode0();
    M = 2'd0; CT = 1'b0; TR = 1'b0;
    clr_tf();
    wr(1'b1, 1'b0, 8'h1F);
    wr(1'b0, 1'b1, 8'hFF);
    CT = 1'b1; TR = 1'b1;
    // One T falling edge held 8 CLK; CE on every fourth cycle.
    exp_q.push_back('{"m0_wrap", 8'h00, 8'h00, 1'b1});
    for (int i = 0; i < 8; i++) begin
      T  = 1'b0;
      CE = (i % 4 == 3);
      @(negedge CLK);
    end
    CE = 1'b0;
    // Two-cycle glitch that never lines up with a CE sample.
    exp_q.push_back('{"m0_glitch", 8'h00, 8'h00, 1'b1});
    for (int j = 0; j < 12; j++) begin
      T  = (j == 6 || j == 7) ? 1'b0 : 1'b1;
      CE = (j % 4 == 3);
      @(negedge CLK);
      if (j == 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
          errors++;
          $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
                   e.name, TH, TL, TF, e.th, e.tl, e.tf);
        end
      end
    end
    CE = 1'b0; T = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
      errors++;
      $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
               e.name, TH, TL, TF, e.th, e.tl, e.tf);
    end
    // TL[7:5] must hold while the low five bits carry into TH.
    CT = 1'b0;
    wr(1'b1, 1'b0, 8'hFF);
    wr(1'b0, 1'b1, 8'h12);
    exp_q.push_back('{"m0_tl_hi_hold", 8'h13, 8'hE0, 1'b1});
    ce_pulse();
    e = exp_q.pop_front();
    checks++;
    if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
      errors++;
      $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
               e.name, TH, TL, TF, e.th, e.tl, e.tf);
    end
  endtask

  task automatic test_mode2();
    M = 2'd2; CT = 1'b0; TR = 1'b0;
    clr_tf();
    wr(1'b0, 1'b1, 8'hA0);
    wr(1'b1, 1'b0, 8'hFE);
    TR = 1'b1;
    exp_q.push_back('{"m2_ff", 8'hA0, 8'hFF, 1'b0});
    exp_q.push_back('{"m2_reload", 8'hA0, 8'hA0, 1'b1});
    exp_q.push_back('{"m2_a1", 8'hA0, 8'hA1, 1'b1});
    for (int i = 0; i < 3; i++) begin
      ce_pulse();
      e = exp_q.pop_front();
      checks++;
      if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
        errors++;
        $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
                 e.name, TH, TL, TF, e.th, e.tl, e.tf);
      end
    end
  endtask

  task automatic test_tfclr_write();
    M = 2'd1; CT = 1'b0; TR = 1'b0;
    clr_tf();
    wr(1'b1, 1'b1, 8'hFF);
    TR = 1'b1;
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin exp_q.push_back('{"ovf_vs_clr", 8'h00, 8'h00, 1'b1});
                 CE = 1'b1; TFCLR = 1'b1; end
        1: begin exp_q.push_back('{"tfclr", 8'h00, 8'h00, 1'b0});
                 TFCLR = 1'b1; end
        2: begin exp_q.push_back('{"wrl_vs_tick", 8'h00, 8'h55, 1'b0});
                 CE = 1'b1; WRL = 1'b1; DIN = 8'h55; end
        3: begin exp_q.push_back('{"wr_both", 8'h77, 8'h77, 1'b0});
                 CE = 1'b1; WRL = 1'b1; WRH = 1'b1; DIN = 8'h77; end
        default: begin exp_q.push_back('{"tr_off", 8'h77, 8'h77, 1'b0});
                 TR = 1'b0; CE = 1'b1; end
      endcase
      @(negedge CLK);
      CE = 1'b0; TFCLR = 1'b0; WRL = 1'b0; WRH = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
        errors++;
        $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
                 e.name, TH, TL, TF, e.th, e.tl, e.tf);
      end
    end
  endtask

  task automatic test_hold_and_mode_change();
    TR = 1'b1; M = 2'd3;
    exp_q.push_back('{"m3_hold", 8'h77, 8'h77, 1'b0});
    exp_q.push_back('{"m1_after_m3", 8'h77, 8'h78, 1'b0});
    ce_pulse();
    ce_pulse();
    e = exp_q.pop_front();
    checks++;
    if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
      errors++;
      $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
               e.name, TH, TL, TF, e.th, e.tl, e.tf);
    end
    M = 2'd1;
    @(negedge CLK);
    ce_pulse();
    e = exp_q.pop_front();
    checks++;
    if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
      errors++;
      $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
               e.name, TH, TL, TF, e.th, e.tl, e.tf);
    end
  endtask

  task automatic test_no_stale_edge();
    TR = 1'b0; CT = 1'b1; M = 2'd1;
    T = 1'b0;
    repeat (2) ce_pulse();
    TR = 1'b1;
    exp_q.push_back('{"no_stale", 8'h77, 8'h78, 1'b0});
    repeat (2) ce_pulse();
    T = 1'b1;
    ce_pulse();
    e = exp_q.pop_front();
    checks++;
    if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
      errors++;
      $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
               e.name, TH, TL, TF, e.th, e.tl, e.tf);
    end
  endtask

  task automatic test_async_reset();
    CT = 1'b0; M = 2'd1; TR = 1'b1;
    wr(1'b1, 1'b1, 8'hFF);
    ce_pulse();
    wr(1'b1, 1'b0, 8'h34);
    wr(1'b0, 1'b1, 8'h12);
    exp_q.push_back('{"preset_1234", 8'h12, 8'h34, 1'b1});
    exp_q.push_back('{"async_rst", 8'h00, 8'h00, 1'b0});
    e = exp_q.pop_front();
    checks++;
    if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
      errors++;
      $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
               e.name, TH, TL, TF, e.th, e.tl, e.tf);
    end
    #1 RSTdash = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
      errors++;
      $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
               e.name, TH, TL, TF, e.th, e.tl, e.tf);
    end
    @(negedge CLK);
    RSTdash = 1'b1;
    @(negedge CLK);
  endtask

`ifdef COUNTER_GATE_EN
  task automatic test_gate();
    CT = 1'b0; M = 2'd1; TR = 1'b1;
    GATE = 1'b1; INT = 1'b0;
    repeat (2) @(negedge CLK);
    exp_q.push_back('{"gate_block", 8'h00, 8'h00, 1'b0});
    exp_q.push_back('{"gate_int", 8'h00, 8'h01, 1'b0});
    repeat (2) ce_pulse();
    e = exp_q.pop_front();
    checks++;
    if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
      errors++;
      $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
               e.name, TH, TL, TF, e.th, e.tl, e.tf);
    end
    INT = 1'b1;
    repeat (2) @(negedge CLK);
    ce_pulse();
    e = exp_q.pop_front();
    checks++;
    if ({TH, TL, TF} !== {e.th, e.tl, e.tf}) begin
      errors++;
      $display("FAIL %s: got TH=%h TL=%h TF=%b, expected TH=%h TL=%h TF=%b",
               e.name, TH, TL, TF, e.th, e.tl, e.tf);
    end
    GATE = 1'b0; INT = 1'b0;
  endtask
`endif

  initial begin
    RSTdash = 1'b0;
    T = 1'b1; CE = 1'b0; TR = 1'b0; CT = 1'b0; M = 2'd0;
    WRL = 1'b0; WRH = 1'b0; DIN = 8'h00; TFCLR = 1'b0;
`ifdef COUNTER_GATE_EN
    GATE = 1'b0; INT = 1'b0;
`endif
    test_reset();
    test_mode1();
    test_mode0();
    test_mode2();
    test_tfclr_write();
    test_hold_and_mode_change();
    test_no_stale_edge();
    test_async_reset();
`ifdef COUNTER_GATE_EN
    test_gate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
